// File: rtl/reduce_drain_ctrl_pkg.sv
// Shared types for the lane-reduction drain scheduler.
// Holds the FSM encoding and the lane-slice helper.
package reduce_drain_ctrl_pkg;

    localparam int NUM_DEF   = 8;
    localparam int WIDTH_DEF = 5;
    localparam int IDX_W_DEF = 3;
    localparam int CNT_W_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    // Lane k lives at bits [k*width +: width] of a packed lane vector.
    function automatic int lane_lo(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/reduce_drain_ctrl_if.sv
// Capture/drain bus between lane producers, scheduler and consumer.
// slave is the scheduler side, master is the driving environment.
interface reduce_drain_ctrl_if #(
    parameter int NUM   = 8,
    parameter int WIDTH = 5,
    parameter int IDX_W = 3,
    parameter int CNT_W = 4
);
    logic                 start_i;
    logic [NUM*WIDTH-1:0] data_i;
    logic [NUM-1:0]       rd_i;
    logic                 abort_i;
    logic                 ready_i;
    logic                 valid_o;
    logic [WIDTH-1:0]     data_o;
    logic [IDX_W-1:0]     idx_o;
    logic                 busy_o;
    logic                 done_o;
    logic [CNT_W-1:0]     count_o;

    modport slave (
        input  start_i, data_i, rd_i, abort_i, ready_i,
        output valid_o, data_o, idx_o, busy_o, done_o, count_o
    );

    modport master (
        output start_i, data_i, rd_i, abort_i, ready_i,
        input  valid_o, data_o, idx_o, busy_o, done_o, count_o
    );
endinterface

// File: rtl/reduce_drain_ctrl_lowest_set_sel.sv
// Lowest-index-wins lane picker; all outputs zero on an empty mask.
module lowest_set_sel
    import reduce_drain_ctrl_pkg::*;
#(
    parameter int NUM   = 8,
    parameter int WIDTH = 5,
    parameter int IDX_W = 3
) (
    input  logic [NUM-1:0]       pend,
    input  logic [NUM*WIDTH-1:0] data,
    output logic                 found,
    output logic [IDX_W-1:0]     idx,
    output logic [WIDTH-1:0]     sel
);

    // Scan high to low so the lowest set lane is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        sel   = '0;
        for (int k = NUM - 1; k >= 0; k--) begin
            if (pend[k]) begin
                found = 1'b1;
                idx   = IDX_W'(k);
                sel   = data[lane_lo(k, WIDTH) +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/reduce_drain_ctrl.sv
// Batch drain scheduler: snapshot pending lanes on start, emit them
// lowest index first over valid/ready, then pulse done.
module reduce_drain_ctrl
    import reduce_drain_ctrl_pkg::*;
#(
    parameter int NUM   = NUM_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDX_W = IDX_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    reduce_drain_ctrl_if.slave bus
);

    state_e               state_q, state_d;
    logic [NUM-1:0]       pend_q, pend_d;
    logic [NUM*WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 sel_found;
    logic [IDX_W-1:0]     sel_idx;
    logic [WIDTH-1:0]     sel_data;
    logic [NUM-1:0]       sel_mask;
    logic [NUM-1:0]       pend_rest;
    logic                 valid;
    logic                 fire;

    lowest_set_sel #(
        .NUM   (NUM),
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_sel (
        .pend  (pend_q),
        .data  (data_q),
        .found (sel_found),
        .idx   (sel_idx),
        .sel   (sel_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid     = (state_q == S_DRAIN) && sel_found;
    assign fire      = valid && bus.ready_i;
    assign sel_mask  = NUM'(1) << sel_idx;
    assign pend_rest = pend_q & ~sel_mask;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    data_d  = bus.data_i;
                    pend_d  = bus.rd_i;
                    cnt_d   = '0;
                    state_d = (|bus.rd_i) ? S_DRAIN : S_DONE;
                end
            end
            S_DRAIN: begin
                if (fire) begin
                    pend_d = pend_rest;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (pend_rest == '0)
                        state_d = S_DONE;
                end
                // A same-cycle transfer still counts; the rest are dropped.
                if (bus.abort_i) begin
                    pend_d  = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.valid_o = valid;
        bus.data_o  = valid ? sel_data : '0;
        bus.idx_o   = valid ? sel_idx : '0;
        bus.busy_o  = (state_q == S_DRAIN) || (state_q == S_DONE);
        bus.done_o  = (state_q == S_DONE);
        bus.count_o = cnt_q;
    end

endmodule
